// File: rtl/pulse_emulator.sv
// rtl/pulse_emulator.sv - synthetic ADC source producing baseline plus flat-top/exponential-decay pulses
// Sample path: trigger -> FSM (IDLE/TOP/DECAY) drives v -> registered saturated baseline+v.
module pulse_emulator #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        adc_clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        trig_mode,
  input  logic                        fire,
  input  logic signed [ADC_WIDTH-1:0] baseline,
  input  logic signed [ADC_WIDTH-1:0] amplitude,
  input  logic [7:0]                  top_len,
  input  logic [3:0]                  decay_shift,
  input  logic [31:0]                 period,
  output logic [AXIS_TDATA_WIDTH-1:0] adc_dat_a,
  output logic                        pulse_active,
  output logic                        pulse_start,
  output logic [31:0]                 pulse_count,
  output logic [15:0]                 missed_count
);

  localparam int VW = ADC_WIDTH + 1;
  localparam int SW = ADC_WIDTH + 2;
  localparam logic signed [SW-1:0] L_MAX = SW'(2 ** (ADC_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] L_MIN = ~L_MAX;

  typedef enum logic [1:0] {S_IDLE, S_TOP, S_DECAY} state_t;

  state_t                 r_state;
  logic signed [VW-1:0]   r_v;
  logic [7:0]             r_top_cnt;
  logic [3:0]             r_shift;
  logic [31:0]            r_timer;
  logic                   r_first;

  logic [31:0]            w_period_eff;
  logic                   w_wrap;
  logic                   w_trigger;
  logic [VW-1:0]          w_mag;
  logic                   w_small;
  logic signed [VW-1:0]   w_v_next;
  logic signed [SW-1:0]   w_sum;
  logic [ADC_WIDTH-1:0]   w_sat;

  assign w_period_eff = (period < 32'd2) ? 32'd2 : period;
  assign w_wrap       = (r_timer >= w_period_eff - 32'd1);
  assign w_trigger    = enable & (trig_mode ? fire : w_wrap);

  // Decay stops once |v| < 2^s; the same test also ends the flat top so the
  // last TOP cycle doubles as the first decay step.
  assign w_mag    = r_v[VW-1] ? -r_v : r_v;
  assign w_small  = (32'(w_mag) < (32'd1 << r_shift));
  assign w_v_next = r_v - (r_v >>> r_shift);

  assign w_sum = {{2{baseline[ADC_WIDTH-1]}}, baseline} + {r_v[VW-1], r_v};
  assign w_sat = (w_sum > L_MAX) ? L_MAX[ADC_WIDTH-1:0] :
                 (w_sum < L_MIN) ? L_MIN[ADC_WIDTH-1:0] : w_sum[ADC_WIDTH-1:0];

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      r_timer <= 32'd0;
    end else if (!enable || trig_mode) begin
      r_timer <= 32'd0;
    end else if (w_wrap) begin
      r_timer <= 32'd0;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_v          <= '0;
      r_top_cnt    <= 8'd0;
      r_shift      <= 4'd0;
      r_first      <= 1'b0;
      pulse_count  <= 32'd0;
      missed_count <= 16'd0;
      adc_dat_a    <= '0;
      pulse_active <= 1'b0;
      pulse_start  <= 1'b0;
    end else begin
      adc_dat_a    <= {{(AXIS_TDATA_WIDTH-ADC_WIDTH){w_sat[ADC_WIDTH-1]}}, w_sat};
      pulse_active <= (r_state != S_IDLE);
      pulse_start  <= r_first;
      r_first      <= 1'b0;

      if (w_trigger && r_state != S_IDLE && missed_count != 16'hFFFF)
        missed_count <= missed_count + 16'd1;

      case (r_state)
        S_IDLE: begin
          r_v <= '0;
          if (w_trigger) begin
            r_state   <= S_TOP;
            r_v       <= {amplitude[ADC_WIDTH-1], amplitude};
            r_top_cnt <= top_len;
            r_shift   <= decay_shift;
            r_first   <= 1'b1;
            if (pulse_count != 32'hFFFF_FFFF)
              pulse_count <= pulse_count + 32'd1;
          end
        end
        S_TOP: begin
          if (r_top_cnt != 8'd0) begin
            r_top_cnt <= r_top_cnt - 8'd1;
          end else if (w_small) begin
            r_v     <= '0;
            r_state <= S_IDLE;
          end else begin
            r_v     <= w_v_next;
            r_state <= S_DECAY;
          end
        end
        S_DECAY: begin
          if (w_small) begin
            r_v     <= '0;
            r_state <= S_IDLE;
          end else begin
            r_v <= w_v_next;
          end
        end
        default: begin
          r_v     <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
